// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter
//   Two-port round-robin arbiter in front of a single-port register file of
//   2**ADDR_W words x DATA_W bits. The storage is built from D flip-flops.
//   Each access takes two edges: in IDLE the winner's command is latched and
//   gnt pulses, and on the following ACCESS edge the write commits or the
//   read data is registered. At most one access runs every two cycles.
//
// Ports
//   clk                       system clock, rising edge
//   rst_n                     synchronous active-low reset
//   req0/1                    level request; command fields valid while high
//   we0/1                     1 = write, 0 = read
//   addr0/1  [ADDR_W-1:0]     word address
//   wdata0/1 [DATA_W-1:0]     write data
//   gnt0/1                    one-cycle grant pulse (registered)
//   rvalid0/1                 one-cycle read-data-valid pulse (registered)
//   rdata0/1 [DATA_W-1:0]     read data, held until the port's next read
//   busy                      high while an access is in its ACCESS cycle
// ---------------------------------------------------------------------------

// One storage word: an enabled D flip-flop bank that clears on reset.
module regfile_arbiter_word #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// Per-port response registers: grant pulse, read-valid pulse and held rdata.
module regfile_arbiter_port #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         gnt_set,   // this port won arbitration this edge
  input  logic         rd_fire,   // this port's read completes this edge
  input  logic [W-1:0] rd_word,   // word addressed by the in-flight command
  output logic         gnt,
  output logic         rvalid,
  output logic [W-1:0] rdata
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt    <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      gnt    <= gnt_set;
      rvalid <= rd_fire;
      // rdata only moves on this port's own reads
      if (rd_fire) rdata <= rd_word;
    end
  end
endmodule

module regfile_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy
);
  localparam int NUM_PORTS = 2;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // -------------------------------------------------------------------------
  // Requester side, gathered into per-port arrays
  // -------------------------------------------------------------------------
  logic [NUM_PORTS-1:0] req;
  cmd_t [NUM_PORTS-1:0] cmd_in;

  assign req       = {req1, req0};
  assign cmd_in[0] = {we0, addr0, wdata0};
  assign cmd_in[1] = {we1, addr1, wdata1};

  // -------------------------------------------------------------------------
  // Arbitration: a lone requester wins; on a tie the port that was not
  // served last wins. last_served resets to 1 so port 0 takes the first tie.
  // -------------------------------------------------------------------------
  logic last_served, last_nxt;
  logic win;

  always_comb begin
    win = 1'b0;
    if (req == 2'b11)  win = ~last_served;
    else if (req[1])   win = 1'b1;
    else               win = 1'b0;
  end

  // -------------------------------------------------------------------------
  // Access sequencer
  // -------------------------------------------------------------------------
  state_t state, state_nxt;
  logic   grant;    // IDLE edge that accepts a command
  logic   access;   // ACCESS edge that performs it

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      state       <= state_nxt;
      last_served <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_served;
    grant     = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        // Requests are only looked at here; a req still high once we are
        // back in IDLE counts as a fresh request.
        if (|req) begin
          grant     = 1'b1;
          last_nxt  = win;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        access    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ACCESS);

  // -------------------------------------------------------------------------
  // Command register: fields are captured only on the granting edge, so the
  // requester may change them freely afterwards.
  // -------------------------------------------------------------------------
  cmd_t cmd_q;
  logic sel_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q <= '0;
      sel_q <= 1'b0;
    end else if (grant) begin
      cmd_q <= cmd_in[win];
      sel_q <= win;
    end
  end

  // -------------------------------------------------------------------------
  // Storage: one flip-flop word per address. Reset clears every word and
  // also suppresses a write that would otherwise commit on that edge.
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0]             wr_en;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DATA_W-1:0]            rd_word;

  always_comb begin
    wr_en = '0;
    if (access && cmd_q.we) wr_en[cmd_q.addr] = 1'b1;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    regfile_arbiter_word #(.W(DATA_W)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_en[i]),
      .d     (cmd_q.wdata),
      .q     (mem_q[i])
    );
  end

  // The addressed word comes from the latched command only, so there is no
  // path from the request inputs to rdata.
  assign rd_word = mem_q[cmd_q.addr];

  // -------------------------------------------------------------------------
  // Per-port response registers
  // -------------------------------------------------------------------------
  logic [NUM_PORTS-1:0]             gnt_set, rd_fire;
  logic [NUM_PORTS-1:0]             gnt, rvalid;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata;

  always_comb begin
    gnt_set = '0;
    rd_fire = '0;
    if (grant)                gnt_set[win]   = 1'b1;
    if (access && !cmd_q.we)  rd_fire[sel_q] = 1'b1;
  end

  regfile_arbiter_port #(.W(DATA_W)) u_port [NUM_PORTS-1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt_set (gnt_set),
    .rd_fire (rd_fire),
    .rd_word (rd_word),
    .gnt     (gnt),
    .rvalid  (rvalid),
    .rdata   (rdata)
  );

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata[0];
  assign rdata1  = rdata[1];

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter
//   Scoreboard bench. The reference model sees the same request levels as the
//   DUT and, from the arbitration rules (one access per two cycles, lone
//   requester wins, ties alternate starting with port 0), predicts each grant
//   and each read response with its cycle stamp. A separate monitor pops and
//   compares whenever the DUT presents gnt/rvalid, and tracks held rdata.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [DW-1:0] rdata0, rdata1;

  // driver-owned stimulus state
  logic          drv_req   [2];
  logic          drv_we    [2];
  logic [AW-1:0] drv_addr  [2];
  logic [DW-1:0] drv_wdata [2];

  assign req0 = drv_req[0];  assign we0 = drv_we[0];
  assign addr0 = drv_addr[0]; assign wdata0 = drv_wdata[0];
  assign req1 = drv_req[1];  assign we1 = drv_we[1];
  assign addr1 = drv_addr[1]; assign wdata1 = drv_wdata[1];

  regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .busy(busy)
  );

  typedef struct { bit we; bit [AW-1:0] addr; bit [DW-1:0] wdata; } cmd_t;
  typedef struct { int port; int cyc; bit [DW-1:0] data; } exp_t;

  cmd_t cq0[$], cq1[$];     // pending commands per port
  exp_t expg[$], expr[$];   // expected grants / read responses

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rst_cyc = -1;
  bit eager = 1'b0;          // hold req continuously while work is queued
  bit late_chg = 1'b0;       // park addr0 at 9 whenever port 0 drops req

  // --------------------------------------------------------------- helpers
  function automatic int qsize(int p);
    return (p != 0) ? cq1.size() : cq0.size();
  endfunction

  function automatic cmd_t qhead(int p);
    return (p != 0) ? cq1[0] : cq0[0];
  endfunction

  function automatic void qpop(int p);
    if (p != 0) begin if (cq1.size() != 0) void'(cq1.pop_front()); end
    else        begin if (cq0.size() != 0) void'(cq0.pop_front()); end
  endfunction

  function automatic void push_cmd(int p, bit we, bit [AW-1:0] a, bit [DW-1:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    if (p != 0) cq1.push_back(c); else cq0.push_back(c);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------- driver
  function automatic void drive_head(int p);
    cmd_t c;
    c = qhead(p);
    drv_req[p] = 1'b1; drv_we[p] = c.we; drv_addr[p] = c.addr; drv_wdata[p] = c.wdata;
  endfunction

  // Fields of an idle port wander randomly: they must not matter.
  function automatic void drop(int p);
    drv_req[p]   = 1'b0;
    drv_we[p]    = 1'($urandom_range(1));
    drv_addr[p]  = (p == 0 && late_chg) ? 4'd9 : AW'($urandom_range(DEPTH - 1));
    drv_wdata[p] = DW'($urandom_range(255));
  endfunction

  always @(negedge clk) begin
    logic [1:0] g;
    g = {gnt1, gnt0};
    for (int p = 0; p < 2; p++) begin
      if (drv_req[p] && g[p]) begin
        qpop(p);
        if (qsize(p) != 0 && (eager || $urandom_range(1) == 1)) drive_head(p);
        else drop(p);
      end else if (!drv_req[p]) begin
        if (qsize(p) != 0 && (eager || $urandom_range(3) != 0)) drive_head(p);
        else drop(p);
      end
    end
  end

  // --------------------------------------------------------------- model
  bit [DW-1:0] mmem [DEPTH];
  int  last = 1;
  bit  free = 1'b1;
  bit  busy_exp = 1'b0;

  always @(posedge clk) begin
    int   w;
    cmd_t c;
    exp_t e;
    cyc++;
    w = -1;
    if (!rst_n) begin
      foreach (mmem[i]) mmem[i] = '0;
      last = 1; free = 1'b1; busy_exp = 1'b0;
      expg.delete(); expr.delete();
      rst_cyc = cyc;
    end else if (!free) begin
      free = 1'b1; busy_exp = 1'b0;      // the access edge; no sampling
    end else begin
      if (drv_req[0] && drv_req[1]) w = 1 - last;
      else if (drv_req[0])          w = 0;
      else if (drv_req[1])          w = 1;
      if (w >= 0 && qsize(w) != 0) begin
        c = qhead(w);
        e.port = w; e.cyc = cyc; e.data = '0;
        expg.push_back(e);
        if (c.we) mmem[c.addr] = c.wdata;
        else begin
          e.cyc = cyc + 1; e.data = mmem[c.addr];
          expr.push_back(e);
        end
        last = w; free = 1'b0; busy_exp = 1'b1;
      end else busy_exp = 1'b0;
    end
  end

  // --------------------------------------------------------------- monitor
  bit [DW-1:0] exp_rd [2];
  int glog[$], gcyc[$];

  always @(negedge clk) begin
    logic [1:0] g, v;
    exp_t e;
    g = {gnt1, gnt0};
    v = {rvalid1, rvalid0};
    if (rst_cyc == cyc) begin exp_rd[0] = '0; exp_rd[1] = '0; end
    chk("gnt_both", 32'(g == 2'b11), 0);
    chk("rvalid_both", 32'(v == 2'b11), 0);
    if (g != 2'b00) begin
      glog.push_back(int'(g[1])); gcyc.push_back(cyc);
      if (expg.size() == 0) chk("gnt_unexpected", 32'(g), 0);
      else begin
        e = expg.pop_front();
        chk("gnt_port", 32'(g), 32'(1 << e.port));
        chk("gnt_cycle", cyc, e.cyc);
      end
    end else if (expg.size() != 0 && expg[0].cyc <= cyc) begin
      e = expg.pop_front();
      chk("gnt_missing", 32'(g), 32'(1 << e.port));
    end
    if (v != 2'b00) begin
      if (expr.size() == 0) chk("rvalid_unexpected", 32'(v), 0);
      else begin
        e = expr.pop_front();
        chk("rvalid_port", 32'(v), 32'(1 << e.port));
        chk("rvalid_cycle", cyc, e.cyc);
        chk("rdata", 32'((e.port != 0) ? rdata1 : rdata0), 32'(e.data));
        exp_rd[e.port] = e.data;
      end
    end else if (expr.size() != 0 && expr[0].cyc <= cyc) begin
      e = expr.pop_front();
      chk("rvalid_missing", 32'(v), 32'(1 << e.port));
      exp_rd[e.port] = e.data;
    end
    chk("rdata0_hold", 32'(rdata0), 32'(exp_rd[0]));
    chk("rdata1_hold", 32'(rdata1), 32'(exp_rd[1]));
    chk("busy", 32'(busy), 32'(busy_exp));
  end

  // --------------------------------------------------------------- sequencing
  task automatic drain(int budget, string name);
    int n;
    n = 0;
    while ((qsize(0) + qsize(1) + expg.size() + expr.size()) != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: work still pending after %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    for (int p = 0; p < 2; p++) begin
      drv_req[p] = 1'b0; drv_we[p] = 1'b0; drv_addr[p] = '0; drv_wdata[p] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_gnt", 32'({gnt1, gnt0}), 0);
    chk("reset_busy", 32'(busy), 0);

    // reset then read
    push_cmd(0, 1'b0, 4'd3, 8'h00);
    drain(50, "t1");
    chk("t1_rdata0", 32'(rdata0), 32'h00);

    // write on port 0, read back on port 1
    push_cmd(0, 1'b1, 4'd5, 8'hA5);
    drain(50, "t2w");
    push_cmd(1, 1'b0, 4'd5, 8'h00);
    drain(50, "t2r");
    chk("t2_rdata1", 32'(rdata1), 32'hA5);
    chk("t2_rdata0_unchanged", 32'(rdata0), 32'h00);

    // address extremes
    push_cmd(0, 1'b1, 4'd15, 8'h3C);
    push_cmd(1, 1'b1, 4'd0,  8'h11);
    drain(50, "t4w");
    push_cmd(0, 1'b0, 4'd15, 8'h00);
    push_cmd(1, 1'b0, 4'd0,  8'h00);
    drain(50, "t4r");
    chk("t4_rdata_a15", 32'(rdata0), 32'h3C);
    chk("t4_rdata_a0", 32'(rdata1), 32'h11);

    // contention fairness right after reset
    do_reset(2);
    glog.delete(); gcyc.delete();
    eager = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_cmd(0, 1'b0, AW'($urandom_range(DEPTH - 1)), 8'h00);
      push_cmd(1, 1'b0, AW'($urandom_range(DEPTH - 1)), 8'h00);
    end
    drain(100, "t3");
    eager = 1'b0;
    chk("fair_count", glog.size(), 8);
    for (int i = 0; i < glog.size() && i < 8; i++) chk("fair_order", glog[i], i % 2);
    for (int i = 1; i < gcyc.size() && i < 8; i++) chk("fair_spacing", gcyc[i] - gcyc[i-1], 2);

    // reset at the access edge of a write
    push_cmd(0, 1'b1, 4'd7, 8'hFF);
    n = 0;
    while (!gnt0 && n < 50) begin @(negedge clk); n++; end
    chk("t5_gnt_seen", 32'(n < 50), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_gnt", 32'({gnt1, gnt0}), 0);
    chk("t5_rvalid", 32'({rvalid1, rvalid0}), 0);
    chk("t5_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push_cmd(0, 1'b0, 4'd7, 8'h00);
    drain(50, "t5r");
    chk("t5_rdata_a7", 32'(rdata0), 32'h00);

    // address moved after the grant must not matter
    push_cmd(0, 1'b1, 4'd2, 8'h5A);
    push_cmd(0, 1'b1, 4'd9, 8'h96);
    drain(50, "t6w");
    late_chg = 1'b1;
    push_cmd(0, 1'b0, 4'd2, 8'h00);
    drain(50, "t6r");
    late_chg = 1'b0;
    chk("t6_rdata_a2", 32'(rdata0), 32'h5A);

    // random traffic on both ports
    for (int i = 0; i < 300; i++)
      push_cmd($urandom_range(1), 1'($urandom_range(1)),
               AW'($urandom_range(DEPTH - 1)), DW'($urandom_range(255)));
    drain(5000, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-port round-robin arbiter in front of a single-port register file of 2**ADDR_W words × DATA_W bits; the storage is an array of D flip-flops.
- Two requesters (port 0, port 1) share the array.
- The block grants one access at a time, sequences each access through a fixed IDLE -> ACCESS cycle, and returns registered read data.
- It is the first memory controller built on top of the team's flip-flop primitives.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W, so every address is in range.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req0  in  1  port 0 request, level; command fields valid while high.
- we0  in  1  port 0 write enable (1 = write, 0 = read).
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 grant, one-cycle pulse.
- rvalid0  out  1  port 0 read data valid, one-cycle pulse.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- busy  out  1  high while state = ACCESS.

Behaviour:
- Reset: when rst_n = 0 at a rising edge:
  - state -> IDLE; last_served -> 1 (port 0 wins the first tie).
  - gnt0/1, rvalid0/1 and busy -> 0; rdata0/1 -> 0.
  - All memory words -> 0.
- Reset overrides everything, including an access in flight: no write commits, no rvalid, no gnt.
- FSM, two states:
  - IDLE: req0/req1 are sampled only in this state.
    - No request: stay in IDLE.
    - One request: that port wins.
    - Both requests: the port != last_served wins.
    - On a winning edge: latch the winner's we/addr/wdata into internal command registers, set gnt_winner = 1 (registered, high for exactly one cycle), update last_served, go to ACCESS.
  - ACCESS: on the next edge, unconditionally:
    - Write: mem[addr] <= wdata; no rvalid.
    - Read: rdata_winner <= mem[addr] and rvalid_winner = 1 for one cycle.
    - gnt -> 0; state -> IDLE.
- Latency:
  - Request sampled at edge k -> gnt high in cycle k..k+1.
  - Read data and rvalid high in cycle k+1..k+2.
  - A written value is readable by any access granted at edge k+2 or later.
- Throughput: at most one access per 2 cycles. Back-to-back requests from both ports alternate 0,1,0,1…
- Requester rule: drop req in the cycle gnt is seen, unless another access is wanted. A req still high when the FSM is back in IDLE is treated as a new request.
- Command fields are sampled only at the granting edge; changes at other times have no effect.
- rdata_x holds its last value until the next read for that port; the other port's rdata is unaffected.
- gnt0 and gnt1 are never high together; the same holds for rvalid0 and rvalid1.
- busy = (state == ACCESS).
- No combinational path from any input to any output.

Test Plan:
- Reset, then read: after rst_n held low for 2 cycles, port 0 reads addr 3 -> gnt0 one cycle after the request edge, rvalid0 one cycle later, rdata0 = 0x00.
- Write then read: port 0 writes 0xA5 to addr 5, then port 1 reads addr 5 -> rdata1 = 0xA5 with rvalid1 pulse; rdata0 unchanged.
- Contention fairness: req0 and req1 held high continuously for 8 cycles -> grants alternate 0,1,0,1 (port 0 first after reset), one grant every 2 cycles, never both.
- Wrap addresses: write 0x3C to addr 15 and 0x11 to addr 0, read both back -> 0x3C and 0x11; no aliasing.
- Reset mid-operation: assert rst_n = 0 at the ACCESS edge of a write of 0xFF to addr 7 -> no write, gnt/rvalid/busy = 0; a later read of addr 7 returns 0x00.
- Late field change: change addr0 from 2 to 9 one cycle after gnt0 -> access uses addr 2.
